ad5328_spi_responder: RTL and testbench

- SPI responder that models the AD5328 8-channel, 12-bit DAC digital interface.
- Receives 16-bit SYNC-framed words, decodes data and control writes, and keeps per-channel input and output registers with LDAC double-buffering.
- Used as the far end of the DAC driver for FPGA loopback, hardware-in-loop emulation and bench self-checking.
- All SPI pins are asynchronous to aclk; they are oversampled.

---
 rtl/ad5328_spi_responder_pkg.sv | 30 +++
 rtl/ad5328_spi_responder_if.sv | 10 +
 rtl/ad5328_spi_responder_sync_edge.sv | 36 +++
 rtl/ad5328_spi_responder.sv | 144 ++++++++++++++
 tb/tb_ad5328_spi_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/ad5328_spi_responder_pkg.sv
// Shared constants, FSM encoding and edge-detector record for the AD5328 SPI responder.
package ad5328_pkg;

    localparam logic [1:0] CMD_GAIN  = 2'b00;
    localparam logic [1:0] CMD_LDAC  = 2'b01;
    localparam logic [1:0] CMD_PWRDN = 2'b10;
    localparam logic [1:0] CMD_RESET = 2'b11;

    localparam logic [1:0] LDAC_CONT   = 2'b00;
    localparam logic [1:0] LDAC_PIN    = 2'b01;
    localparam logic [1:0] LDAC_SINGLE = 2'b10;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int NUM_CH     = 8;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } edge_t;

endpackage

// File: rtl/ad5328_spi_responder_if.sv
// AD5328 serial pins; the DAC driver is the master, the responder the slave.
interface ad5328_spi_if;
    logic dac_sclk;
    logic dac_sync;
    logic dac_din;
    logic dac_ldac;

    modport master (output dac_sclk, output dac_sync, output dac_din, output dac_ldac);
    modport slave  (input  dac_sclk, input  dac_sync, input  dac_din, input  dac_ldac);
endinterface

// File: rtl/ad5328_spi_responder_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, plus rise/fall detection on the result.
module spi_sync_edge
    import ad5328_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic  aclk,
    input  logic  resetn,
    input  logic  async_in,
    output edge_t edge_o
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        edge_o.level = sync_q[STAGES-1];
        edge_o.rise  = sync_q[STAGES-1] & ~prev_q;
        edge_o.fall  = ~sync_q[STAGES-1] & prev_q;
    end
endmodule

// File: rtl/ad5328_spi_responder.sv
// AD5328 digital-interface model: SYNC-framed 16-bit words, input/output registers, LDAC buffering.
module ad5328_spi_responder
    import ad5328_pkg::*;
#(
    parameter int         SYNC_STAGES     = 2,
    parameter logic [1:0] RESET_LDAC_MODE = 2'b01
) (
    input  logic                          aclk,
    input  logic                          resetn,
    ad5328_spi_if.slave                   spi,
    output logic [NUM_CH*DATA_BITS-1:0]   ch_data,
    output logic [NUM_CH-1:0]             ch_update,
    output logic                          frame_valid,
    output logic [FRAME_BITS-1:0]         frame_word,
    output logic                          frame_error,
    output logic [1:0]                    ldac_mode,
    output state_t                        dbg_state
);
    edge_t sclk_e, sync_e, din_e, ldac_e;

    // Idle-high pins reset high so release from reset never looks like an edge.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sclk (.aclk, .resetn, .async_in(spi.dac_sclk), .edge_o(sclk_e));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync (.aclk, .resetn, .async_in(spi.dac_sync), .edge_o(sync_e));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_din  (.aclk, .resetn, .async_in(spi.dac_din),  .edge_o(din_e));
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ldac (.aclk, .resetn, .async_in(spi.dac_ldac), .edge_o(ldac_e));

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]               shift_q, shift_d, word_next;
    logic [NUM_CH-1:0][DATA_BITS-1:0]    in_q, in_d, out_q, out_d;
    logic [1:0]                          mode_q, mode_d;
    logic [NUM_CH-1:0]                   upd_q, upd_d;
    logic                                fv_q, fv_d, fe_q, fe_d;
    logic [FRAME_BITS-1:0]               fw_q, fw_d;
    logic                                last_bit, transfer, sw_reset;

    always_ff @(posedge aclk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    assign last_bit = (cnt_q == CNT_W'(FRAME_BITS - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!sync_e.level) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (sync_e.level)                  state_d = ST_IDLE;
                else if (sclk_e.fall && last_bit)  state_d = ST_DONE;
            end
            ST_DONE:  if (sync_e.level) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        fv_d      = 1'b0;
        fe_d      = 1'b0;
        word_next = {shift_q[FRAME_BITS-2:0], din_e.level};
        case (state_q)
            ST_IDLE: if (!sync_e.level) begin
                shift_d = '0;
                cnt_d   = '0;
            end
            ST_SHIFT: begin
                if (sync_e.level) begin
                    fe_d = (cnt_q != '0);
                end else if (sclk_e.fall) begin
                    shift_d = word_next;
                    cnt_d   = cnt_q + CNT_W'(1);
                    fv_d    = last_bit;
                end
            end
            default: ;
        endcase
    end

    // Register side effects of a committed word, then the LDAC transfer with write-through.
    always_comb begin
        in_d     = in_q;
        mode_d   = mode_q;
        sw_reset = 1'b0;
        fw_d     = fv_d ? word_next : fw_q;
        transfer = (mode_q == LDAC_CONT) || (mode_q == LDAC_SINGLE) || !ldac_e.level;
        if (mode_q == LDAC_SINGLE) mode_d = LDAC_PIN;
        if (fv_d) begin
            if (!word_next[15]) begin
                in_d[word_next[14:12]] = word_next[DATA_BITS-1:0];
            end else begin
                case (word_next[14:13])
                    CMD_LDAC:  mode_d   = word_next[1:0];
                    CMD_RESET: sw_reset = 1'b1;
                    CMD_GAIN, CMD_PWRDN: ;
                    default: ;
                endcase
            end
        end
        out_d = transfer ? in_d : out_q;
        upd_d = '0;
        if (sw_reset) begin
            in_d   = '0;
            out_d  = '0;
            mode_d = RESET_LDAC_MODE;
            upd_d  = '1;
        end else begin
            for (int n = 0; n < NUM_CH; n++) upd_d[n] = (out_d[n] != out_q[n]);
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            cnt_q   <= '0;
            shift_q <= '0;
            in_q    <= '0;
            out_q   <= '0;
            mode_q  <= RESET_LDAC_MODE;
            upd_q   <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            fw_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            in_q    <= in_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            upd_q   <= upd_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            fw_q    <= fw_d;
        end
    end

    assign ch_data     = out_q;
    assign ch_update   = upd_q;
    assign frame_valid = fv_q;
    assign frame_word  = fw_q;
    assign frame_error = fe_q;
    assign ldac_mode   = mode_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_ad5328_spi_responder.sv
// Directed bench for the AD5328 responder: every output event is checked against a queued expectation.
module tb_ad5328_spi_responder;
    import ad5328_pkg::*;

    localparam int W = 2 + 16 + 8 + 2 + 96;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic [95:0] ch_data;
    logic [7:0]  ch_update;
    logic        frame_valid, frame_error;
    logic [15:0] frame_word;
    logic [1:0]  ldac_mode;
    state_t      dbg_state;

    ad5328_spi_if spi ();

    ad5328_spi_responder #(.SYNC_STAGES(2), .RESET_LDAC_MODE(2'b01)) dut (
        .aclk        (aclk),
        .resetn      (resetn),
        .spi         (spi),
        .ch_data     (ch_data),
        .ch_update   (ch_update),
        .frame_valid (frame_valid),
        .frame_word  (frame_word),
        .frame_error (frame_error),
        .ldac_mode   (ldac_mode),
        .dbg_state   (dbg_state)
    );

    always #5 aclk = ~aclk;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [W-1:0]   exp_q[$];
    logic [95:0]    m_ch = '0;
    logic [15:0]    m_fw = '0;
    logic [1:0]     m_mode = 2'b01;

    // ---------------- scoreboard helpers ----------------
    task automatic push_evt(input logic fv, input logic fe, input logic [7:0] upd);
        exp_q.push_back({fv, fe, m_fw, upd, m_mode, m_ch});
    endtask

    task automatic set_ch(input int n, input logic [11:0] v);
        m_ch[12*n +: 12] = v;
    endtask

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge aclk) begin
        logic [W-1:0] act, exp;
        if (resetn && (frame_valid || frame_error || ch_update != 8'h00)) begin
            act = {frame_valid, frame_error, frame_word, ch_update, ldac_mode, ch_data};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: got %h expected none", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL event: got %h expected %h", act, exp);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic spi_bit(input logic b);
        spi.dac_din  = b;
        spi.dac_sclk = 1'b1;
        repeat (4) @(negedge aclk);
        spi.dac_sclk = 1'b0;
        repeat (4) @(negedge aclk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int nbits, input logic raise);
        @(negedge aclk);
        spi.dac_sync = 1'b0;
        repeat (4) @(negedge aclk);
        for (int i = 0; i < nbits; i++) spi_bit(v[nbits-1-i]);
        repeat (2) @(negedge aclk);
        spi.dac_sclk = 1'b1;
        if (raise) begin
            repeat (4) @(negedge aclk);
            spi.dac_sync = 1'b1;
            repeat (8) @(negedge aclk);
        end
    endtask

    task automatic send_word(input logic [15:0] w);
        send_bits({16'h0, w}, 16, 1'b1);
    endtask

    task automatic pulse_ldac(input int n);
        @(negedge aclk);
        spi.dac_ldac = 1'b0;
        repeat (n) @(negedge aclk);
        spi.dac_ldac = 1'b1;
        repeat (6) @(negedge aclk);
    endtask

    task automatic write_ch(input int n, input logic [11:0] v, input logic [7:0] upd);
        m_fw = {1'b0, 3'(n), v};
        if (upd != 8'h00) set_ch(n, v);
        push_evt(1'b1, 1'b0, upd);
        send_word(m_fw);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        spi.dac_sclk = 1'b1;
        spi.dac_sync = 1'b1;
        spi.dac_din  = 1'b0;
        spi.dac_ldac = 1'b1;
        repeat (4) @(negedge aclk);
        check("rst_ch_data",   ch_data,                 96'h0);
        check("rst_ch_update", {88'h0, ch_update},      96'h0);
        check("rst_fv_fe",     {94'h0, frame_valid, frame_error}, 96'h0);
        check("rst_frame_word", {80'h0, frame_word},    96'h0);
        check("rst_ldac_mode", {94'h0, ldac_mode},      96'h1);
        check("rst_state",     {94'h0, dbg_state},      96'h0);
        resetn = 1'b1;
        repeat (6) @(negedge aclk);

        // continuous mode: write lands in ch_data on the commit cycle
        m_fw = 16'hA000; m_mode = LDAC_CONT;
        push_evt(1'b1, 1'b0, 8'h00);
        send_word(16'hA000);
        write_ch(0, 12'hABC, 8'h01);
        check("ch0_cont", {84'h0, ch_data[11:0]}, 96'hABC);

        // pin mode: held until LDAC pulse
        m_fw = 16'hA001; m_mode = LDAC_PIN;
        push_evt(1'b1, 1'b0, 8'h00);
        send_word(16'hA001);
        write_ch(7, 12'h123, 8'h00);
        repeat (10) @(negedge aclk);
        check("ch7_held", {84'h0, ch_data[95:84]}, 96'h0);
        set_ch(7, 12'h123);
        push_evt(1'b0, 1'b0, 8'h80);
        pulse_ldac(3);
        check("ch7_loaded", {84'h0, ch_data[95:84]}, 96'h123);

        // single-shot mode: one transfer on the following cycle, then back to pin mode
        write_ch(3, 12'h055, 8'h00);
        m_fw = 16'hA002; m_mode = LDAC_SINGLE;
        push_evt(1'b1, 1'b0, 8'h00);
        set_ch(3, 12'h055); m_mode = LDAC_PIN;
        push_evt(1'b0, 1'b0, 8'h08);
        send_word(16'hA002);
        check("single_mode_revert", {94'h0, ldac_mode}, 96'h1);
        check("ch3_single", {84'h0, ch_data[47:36]}, 96'h055);

        // truncated frame after 9 falls, then a full frame
        push_evt(1'b0, 1'b1, 8'h00);
        send_bits(32'h0000_005F, 9, 1'b1);
        write_ch(2, 12'hFFF, 8'h00);
        check("ch2_not_transferred", {84'h0, ch_data[35:24]}, 96'h0);
        set_ch(2, 12'hFFF);
        push_evt(1'b0, 1'b0, 8'h04);
        pulse_ldac(2);

        // fill remaining channels in continuous mode, then software reset
        m_fw = 16'hA000; m_mode = LDAC_CONT;
        push_evt(1'b1, 1'b0, 8'h00);
        send_word(16'hA000);
        write_ch(1, 12'h111, 8'h02);
        write_ch(4, 12'h444, 8'h10);
        write_ch(5, 12'h555, 8'h20);
        write_ch(6, 12'h666, 8'h40);
        m_fw = 16'hE000; m_ch = '0; m_mode = RESET_MODE_EXP();
        push_evt(1'b1, 1'b0, 8'hFF);
        send_word(16'hE000);
        check("swreset_mode", {94'h0, ldac_mode}, 96'h1);

        // reset mid-frame: input register contents must not survive
        write_ch(0, 12'h321, 8'h00);
        send_bits(32'h0000_005A, 7, 1'b0);
        resetn = 1'b0;
        repeat (3) @(negedge aclk);
        spi.dac_sync = 1'b1;
        spi.dac_sclk = 1'b1;
        repeat (2) @(negedge aclk);
        resetn = 1'b1;
        m_fw = '0;
        repeat (6) @(negedge aclk);
        check("midrst_frame_word", {80'h0, frame_word}, 96'h0);
        check("midrst_ch_data",    ch_data,             96'h0);
        check("midrst_ldac_mode",  {94'h0, ldac_mode},  96'h1);
        check("midrst_state",      {94'h0, dbg_state},  96'h0);
        pulse_ldac(3);
        check("midrst_inputs_clear", ch_data, 96'h0);

        // sync held low across 20 falls: only the first 16 bits commit
        m_fw = 16'h1234;
        push_evt(1'b1, 1'b0, 8'h00);
        send_bits(32'h0001_234F, 20, 1'b1);
        check("long_frame_idle", {94'h0, dbg_state}, 96'h0);
        m_fw = 16'h5678;
        push_evt(1'b1, 1'b0, 8'h00);
        send_word(16'h5678);

        repeat (20) @(negedge aclk);
        check("pending_events", 96'(exp_q.size()), 96'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [1:0] RESET_MODE_EXP();
        return 2'b01;
    endfunction
endmodule
